// File: rtl/spike_synapse.sv
// spike_synapse: turns a spike train into a leaky, weighted 8-bit synaptic current
// and reports the saturated spike count of each completed window.
module spike_synapse #(
    parameter int DECAY_SHIFT = 3,
    parameter int WINDOW_LOG2 = 8,
    parameter logic [7:0] W_DEFAULT = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spike_in,
    input  logic [7:0] weight_in,
    input  logic       weight_load,
    output logic [7:0] current,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic [7:0] weight
);
    logic [7:0] current_q, current_d, rate_q, rate_d, weight_q, weight_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc, decay, leak;
    logic [8:0] sum;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic rate_valid_q, rate_valid_d, last;

    always_comb begin
        decay = current_q >> DECAY_SHIFT;
        // small currents lose at least 1 per cycle so the tail reaches zero
        leak = (current_q == 8'd0) ? 8'd0 : (decay == 8'd0) ? current_q - 8'd1 : current_q - decay;
        sum = {1'b0, leak} + {1'b0, weight_q};
        current_d = spike_in ? (sum[8] ? 8'hff : sum[7:0]) : leak;
        weight_d = weight_load ? weight_in : weight_q;
        last = &win_q;
        win_d = win_q + WINDOW_LOG2'(1);
        cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + {7'd0, spike_in};
        cnt_d = last ? 8'd0 : cnt_inc;
        rate_d = last ? cnt_inc : rate_q;
        rate_valid_d = last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            current_q <= 8'd0;
            rate_q <= 8'd0;
            rate_valid_q <= 1'b0;
            weight_q <= W_DEFAULT;
            win_q <= '0;
            cnt_q <= 8'd0;
        end else begin
            current_q <= current_d;
            rate_q <= rate_d;
            rate_valid_q <= rate_valid_d;
            weight_q <= weight_d;
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign current = current_q;
    assign rate = rate_q;
    assign rate_valid = rate_valid_q;
    assign weight = weight_q;
endmodule

// File: tb/tb_spike_synapse.sv
// tb_spike_synapse: scoreboard bench; a behavioural model predicts every cycle's
// outputs, plus directed checks of the hand-derived values of each scenario.
module tb_spike_synapse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spike_in = 1'b0;
    logic [7:0] weight_in = 8'd0;
    logic weight_load = 1'b0;
    logic [7:0] current, rate, weight;
    logic rate_valid;

    typedef struct {int cur; int rate; int rv; int w;} exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int m_cur = 0, m_rate = 0, m_rv = 0, m_w = 64, m_win = 0, m_cnt = 0;

    spike_synapse dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .weight_in(weight_in),
        .weight_load(weight_load), .current(current), .rate(rate),
        .rate_valid(rate_valid), .weight(weight)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic step(input bit sp, input bit wl, input int wi, input bit r);
        exp_t e;
        int lk;
        @(negedge clk);
        spike_in = sp;
        weight_load = wl;
        weight_in = 8'(wi);
        rst = r;
        if (r) begin
            m_cur = 0; m_rate = 0; m_rv = 0; m_w = 64; m_win = 0; m_cnt = 0;
        end else begin
            if (m_cur == 0) lk = 0;
            else begin
                lk = m_cur - (m_cur >> 3);
                if (lk == m_cur) lk = m_cur - 1;
            end
            m_cur = sp ? sat(lk + m_w) : lk;
            m_rv = (m_win == 255) ? 1 : 0;
            if (m_rv == 1) begin
                m_rate = sat(m_cnt + int'(sp));
                m_cnt = 0;
            end else m_cnt = sat(m_cnt + int'(sp));
            m_win = (m_win + 1) % 256;
            if (wl) m_w = wi;
        end
        e.cur = m_cur; e.rate = m_rate; e.rv = m_rv; e.w = m_w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_current", 32'(current), e.cur);
        check("sb_rate", 32'(rate), e.rate);
        check("sb_rate_valid", 32'(rate_valid), e.rv);
        check("sb_weight", 32'(weight), e.w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 200, 1'b1);
        check("reset_current", 32'(current), 0);
        check("reset_weight", 32'(weight), 64);
        check("reset_rate_valid", 32'(rate_valid), 0);
        // single spike decay
        step(1'b1, 1'b0, 0, 1'b0);
        check("decay_64", 32'(current), 64);
        step(1'b0, 1'b0, 0, 1'b0);
        check("decay_56", 32'(current), 56);
        step(1'b0, 1'b0, 0, 1'b0);
        check("decay_49", 32'(current), 49);
        step(1'b0, 1'b0, 0, 1'b0);
        check("decay_43", 32'(current), 43);
        step(1'b0, 1'b0, 0, 1'b0);
        check("decay_38", 32'(current), 38);
        idle(60);
        check("decay_zero", 32'(current), 0);
        // saturation with weight 200
        step(1'b0, 1'b1, 200, 1'b0);
        check("wload_no_spike", 32'(current), 0);
        check("wload_200", 32'(weight), 200);
        step(1'b1, 1'b0, 0, 1'b0);
        check("sat_first", 32'(current), 200);
        step(1'b1, 1'b0, 0, 1'b0);
        check("sat_255", 32'(current), 255);
        idle(80);
        check("sat_decay_zero", 32'(current), 0);
        // weight load coinciding with a spike uses the old weight
        step(1'b0, 1'b1, 64, 1'b0);
        step(1'b1, 1'b1, 10, 1'b0);
        check("old_weight", 32'(current), 64);
        check("new_weight_rb", 32'(weight), 10);
        step(1'b1, 1'b0, 0, 1'b0);
        check("new_weight_add", 32'(current), 66);
        idle(60);
        // rate saturation from a fresh, aligned window
        step(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 0, 1'b0);
        check("rate_sat", 32'(rate), 255);
        check("rate_valid_256", 32'(rate_valid), 1);
        for (int i = 0; i < 256; i++) step(i % 4 == 0, 1'b0, 0, 1'b0);
        check("rate_64", 32'(rate), 64);
        check("rate_valid_64", 32'(rate_valid), 1);
        for (int i = 0; i < 256; i++) step(i == 255, 1'b0, 0, 1'b0);
        check("rate_last_cycle", 32'(rate), 1);
        idle(256);
        check("rate_empty", 32'(rate), 0);
        check("rate_valid_empty", 32'(rate_valid), 1);
        // mid-window reset with current 120 and count 30
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 120, 1'b0);
        for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 0, 1'b0);
        idle(80);
        step(1'b1, 1'b0, 0, 1'b0);
        check("pre_rst_current", 32'(current), 120);
        step(1'b1, 1'b0, 0, 1'b1);
        check("mid_rst_current", 32'(current), 0);
        check("mid_rst_rate", 32'(rate), 0);
        check("mid_rst_weight", 32'(weight), 64);
        idle(255);
        check("no_early_valid", 32'(rate_valid), 0);
        idle(1);
        check("valid_after_rst", 32'(rate_valid), 1);
        check("rate_after_rst", 32'(rate), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
